// File: rtl/tx_bytes_pkg.sv
// rtl/tx_bytes_pkg.sv - shared states, CRC constants and frame geometry for tx_bytes
package tx_bytes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SEND,
    CRC_L,
    CRC_H
  } state_t;

  localparam logic [15:0] CRC16_INIT   = 16'hffff;
  localparam logic [15:0] CRC16_POLY   = 16'ha001;
  localparam int          HDR_LEN      = 3;
  localparam int          CRC_LEN      = 2;
  localparam logic [7:0]  LEN_ADDR     = 8'(HDR_LEN - 1);
  localparam logic [7:0]  MAX_LEN_HW   = 8'(256 - HDR_LEN);
  localparam logic [7:0]  MAX_LEN_USER = 8'(256 - HDR_LEN - CRC_LEN);

  // Last buffer address of a frame: header + payload, plus the CRC bytes when they live in the buffer
  function automatic logic [7:0] last_addr(input logic [7:0] len, input logic user);
    return user ? len + 8'(HDR_LEN + CRC_LEN - 1) : len + 8'(HDR_LEN - 1);
  endfunction

  // A length the 8-bit buffer address cannot cover is refused
  function automatic logic oversize(input logic [7:0] len, input logic user);
    return len > (user ? MAX_LEN_USER : MAX_LEN_HW);
  endfunction

endpackage

// File: rtl/crc16_byte.sv
// rtl/crc16_byte.sv - combinational CRC-16/MODBUS single-byte update, shared with the receive path
module crc16_byte
  import tx_bytes_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  output logic [15:0] crc_out
);

  // Fold one byte into the reflected CRC, LSB first
  always_comb begin
    crc_out = crc_in ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      if (crc_out[0]) crc_out = (crc_out >> 1) ^ CRC16_POLY;
      else            crc_out = crc_out >> 1;
    end
  end

endmodule

// File: rtl/tx_bytes.sv
// rtl/tx_bytes.sv - frame reader from ping-pong RAM to byte serializer; TX_BYTES_USER_CRC_EN adds user_crc
module tx_bytes
  import tx_bytes_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
`ifdef TX_BYTES_USER_CRC_EN
  input  logic       user_crc,
`endif
  input  logic       abort,
  output logic       error,
  input  logic       unread,
  input  logic [7:0] rd_byte,
  output logic [7:0] rd_addr,
  output logic       rd_done,
  output logic [7:0] ser_data,
  output logic       ser_valid,
  input  logic       ser_ready,
  output logic       ser_last
);

  state_t      state;
  logic        fetch_wait;
  logic [8:0]  byte_cnt;
  logic [7:0]  data_len;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic        user_q;
  logic        user_sel;
  logic        hs;
  logic [7:0]  last_a;

`ifdef TX_BYTES_USER_CRC_EN
  assign user_sel = user_crc;
`else
  assign user_sel = 1'b0;
`endif

  assign hs     = ser_valid & ser_ready;
  assign last_a = last_addr(data_len, user_q);

  crc16_byte u_crc (
    .crc_in  (crc),
    .data    (ser_data),
    .crc_out (crc_next)
  );

  // Frame sequencer; RAM read latency is one cycle, so FETCH spends one cycle letting rd_addr reach the RAM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      fetch_wait <= 1'b0;
      byte_cnt   <= '0;
      data_len   <= '0;
      crc        <= CRC16_INIT;
      user_q     <= 1'b0;
      rd_addr    <= '0;
      rd_done    <= 1'b0;
      error      <= 1'b0;
      ser_data   <= '0;
      ser_valid  <= 1'b0;
      ser_last   <= 1'b0;
    end else begin
      rd_done <= 1'b0;
      error   <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        fetch_wait <= 1'b0;
        ser_valid  <= 1'b0;
        ser_last   <= 1'b0;
        rd_done    <= (state != IDLE);
      end else begin
        case (state)
          IDLE: begin
            if (unread) begin
              state      <= FETCH;
              fetch_wait <= 1'b1;
              rd_addr    <= '0;
              byte_cnt   <= '0;
              data_len   <= '0;
              crc        <= CRC16_INIT;
              user_q     <= user_sel;
            end
          end
          FETCH: begin
            if (fetch_wait) begin
              fetch_wait <= 1'b0;
            end else if (rd_addr == LEN_ADDR && oversize(rd_byte, user_q)) begin
              error   <= 1'b1;
              rd_done <= 1'b1;
              state   <= IDLE;
            end else begin
              ser_data  <= rd_byte;
              ser_valid <= 1'b1;
              ser_last  <= user_q && (rd_addr == last_a);
              if (rd_addr == LEN_ADDR) data_len <= rd_byte;
              state     <= SEND;
            end
          end
          SEND: begin
            if (hs) begin
              crc      <= crc_next;
              byte_cnt <= byte_cnt + 9'd1;
              if (rd_addr != last_a) begin
                rd_addr    <= rd_addr + 8'd1;
                ser_valid  <= 1'b0;
                fetch_wait <= 1'b1;
                state      <= FETCH;
              end else if (user_q) begin
                ser_valid <= 1'b0;
                ser_last  <= 1'b0;
                rd_done   <= 1'b1;
                state     <= IDLE;
              end else begin
                ser_data <= crc_next[7:0];
                state    <= CRC_L;
              end
            end
          end
          CRC_L: begin
            if (hs) begin
              ser_data <= crc[15:8];
              ser_last <= 1'b1;
              state    <= CRC_H;
            end
          end
          CRC_H: begin
            if (hs) begin
              ser_valid <= 1'b0;
              ser_last  <= 1'b0;
              rd_done   <= 1'b1;
              state     <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
